fft_stage_sequencer: RTL
========================

Name: fft_stage_sequencer

Overview:
Control FSM for one N=128 parallel FFT core. It walks the radix-2 stages in order. For each stage it selects the matching constant twiddle-coefficient bank (one 32-entry packed {re,im} ROM per stage/bank) and pulses a load into the butterfly array's coefficient register. It then issues butterfly beats, waits out the butterfly pipeline, and swaps the ping-pong data buffers. One instance sits between the top-level frame control and the butterfly array / coefficient mux.

Parameters:
NSTAGES, 7, number of FFT stages (log2 of 128)
BEATS, 2, butterfly-array beats per stage (64 butterflies / 32 lanes)
PIPE_LAT, 3, butterfly pipeline drain cycles after the last beat; 0 is legal
SW, 3, stage index width, clog2(NSTAGES)
BW, 1, beat index width, max(1, clog2(BEATS))

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous, active-low reset
start  in  1  frame start request, sampled only in IDLE
abort  in  1  synchronous abort, returns to IDLE with no done pulse
hold  in  1  stall request; freezes beat issue in RUN only
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse in DONE state
stage_idx  out  SW  current stage, 0..NSTAGES-1
coeff_sel  out  SW  coefficient bank select, equals stage_idx
coeff_load  out  1  one-cycle strobe: capture the selected coefficient bank
bf_en  out  1  butterfly array enable for the current beat
beat_idx  out  BW  beat number within the stage
rd_bank  out  1  ping-pong read bank, equals stage_idx[0]; write bank is its inverse

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; stage_idx=0, beat_idx=0, drain counter=0, all outputs 0.
- All outputs are decoded from registered state and counters (Moore). There is no combinational path from inputs to outputs.
- States: IDLE, LOAD, RUN, DRAIN, DONE.
- IDLE: start=1 moves to LOAD and clears stage_idx to 0. The start pulse may be 1 cycle wide.
- LOAD: lasts exactly 1 cycle. coeff_load=1 and coeff_sel=stage_idx. The coefficient bank is stable through LOAD and all of RUN. Next state is RUN with beat_idx=0.
- RUN with hold=0: bf_en=1 and beat_idx advances by 1 each cycle.
- RUN with hold=1: bf_en=0 and beat_idx is frozen.
- RUN exit: the cycle with bf_en=1 and beat_idx=BEATS-1 moves to DRAIN and loads the drain counter with PIPE_LAT.
- DRAIN: bf_en=0 and the counter decrements each cycle; hold is ignored. When the count is exhausted (immediately if PIPE_LAT=0, i.e. DRAIN is skipped), the next state is chosen:
  - stage_idx<NSTAGES-1: increment stage_idx, which toggles rd_bank, then go to LOAD.
  - otherwise: go to DONE.
- DONE: lasts 1 cycle. done=1 and busy=1. Next state is IDLE. stage_idx holds NSTAGES-1 until the next start.
- start is ignored whenever busy=1, including during DONE. A start in the first IDLE cycle after DONE is accepted.
- abort=1 in any non-IDLE state:
  - Next state is IDLE, with stage_idx and beat_idx cleared to 0.
  - No done pulse.
  - abort has priority over every other transition.
  - In IDLE, abort has priority over start.
- Stage cost with no hold: 1 + BEATS + PIPE_LAT cycles. If start is sampled at edge 0, LOAD is cycle 1 and DONE is cycle 1 + NSTAGES*(1+BEATS+PIPE_LAT). With defaults DONE is cycle 43. Each hold cycle in RUN adds one cycle.
- Invariant: coeff_load and bf_en are never high in the same cycle.
- Invariant: bf_en is never high outside RUN.
- Invariant: exactly NSTAGES coeff_load pulses and NSTAGES*BEATS bf_en cycles occur per completed frame.

Test Plan:
- Reset mid-RUN: assert rst_n=0 → all outputs 0 immediately (asynchronous). Release, pulse start → LOAD in the following cycle.
- Defaults, start at edge 0, hold=0:
  - done at cycle 43; busy high for cycles 1..43.
  - coeff_load at cycles 1,7,13,19,25,31,37 with coeff_sel 0..6.
  - rd_bank sequence 0,1,0,1,0,1,0.
  - 14 bf_en cycles total.
- hold=1 for 3 cycles during stage 2 beat 1 → bf_en low and beat_idx frozen at 1 for those cycles; done delayed to cycle 46.
- PIPE_LAT=0, BEATS=1 → 2 cycles per stage; done at cycle 15; no DRAIN cycle appears.
- abort during DRAIN of stage 4 → busy=0 next cycle, no done pulse, stage_idx=0. A fresh start then gives a full-length run with done at cycle 43.
- start held high continuously → back-to-back frames. Each frame's done is followed by one IDLE cycle, then LOAD. Pulses of start while busy=1 cause no effect.

Source files
------------

// File: rtl/fft_stage_sequencer_if.sv
// Handshake/status bundle between the FFT stage sequencer and its neighbours
// (frame control on one side, butterfly array / coefficient mux on the other).
//
// Signals:
//   start      frame start request (into sequencer)
//   abort      synchronous abort (into sequencer)
//   hold       stall request for beat issue (into sequencer)
//   busy       sequencer is working on a frame
//   done       one-cycle end-of-frame pulse
//   stage_idx  current radix-2 stage
//   coeff_sel  twiddle bank select (same as stage_idx)
//   coeff_load strobe to capture the selected twiddle bank
//   bf_en      butterfly array enable for the current beat
//   beat_idx   beat number within the stage
//   rd_bank    ping-pong read bank; the write bank is its inverse
//
// master: the sequencer side. slave: the frame control / consumer side.
interface fft_stage_sequencer_if #(
    parameter int SW = 3,
    parameter int BW = 1
);
    logic          start;
    logic          abort;
    logic          hold;
    logic          busy;
    logic          done;
    logic [SW-1:0] stage_idx;
    logic [SW-1:0] coeff_sel;
    logic          coeff_load;
    logic          bf_en;
    logic [BW-1:0] beat_idx;
    logic          rd_bank;

    modport master (
        input  start, abort, hold,
        output busy, done, stage_idx, coeff_sel, coeff_load, bf_en, beat_idx, rd_bank
    );

    modport slave (
        output start, abort, hold,
        input  busy, done, stage_idx, coeff_sel, coeff_load, bf_en, beat_idx, rd_bank
    );
endinterface

// File: rtl/fft_stage_sequencer.sv
// Control FSM for one parallel FFT core. Walks the radix-2 stages in order:
// per stage it strobes a twiddle-bank load, issues the butterfly beats,
// waits out the butterfly pipeline and then flips the ping-pong buffers.
//
// Ports:
//   clk    system clock, all state on the rising edge
//   rst_n  asynchronous active-low reset
//   bus    fft_stage_sequencer_if.master (start/abort/hold in, status and
//          butterfly/coefficient control out)
//
// Every output is decoded from registered state only. Because of that, hold
// is sampled at a clock edge and suppresses the beat of the following cycle:
// a registered "stalled" flag carries it into the RUN cycle it freezes.
module fft_stage_sequencer #(
    parameter int NSTAGES  = 7,
    parameter int BEATS    = 2,
    parameter int PIPE_LAT = 3,
    parameter int SW       = 3,
    parameter int BW       = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fft_stage_sequencer_if.master bus
);

    localparam int CW = (PIPE_LAT < 2) ? 1 : $clog2(PIPE_LAT + 1);
    localparam logic [SW-1:0] LAST_STAGE = SW'(NSTAGES - 1);
    localparam logic [BW-1:0] LAST_BEAT  = BW'(BEATS - 1);
    localparam logic [CW-1:0] DRAIN_LOAD = CW'(PIPE_LAT);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [SW-1:0] stage_idx;
    logic [SW-1:0] stage_n;
    logic [BW-1:0] beat_idx;
    logic [BW-1:0] beat_n;
    logic [CW-1:0] drain_cnt;
    logic [CW-1:0] drain_n;
    logic          stalled;
    logic          stalled_n;
    logic          stage_end;

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            stage_idx <= '0;
            beat_idx  <= '0;
            drain_cnt <= '0;
            stalled   <= 1'b0;
        end else begin
            state     <= state_n;
            stage_idx <= stage_n;
            beat_idx  <= beat_n;
            drain_cnt <= drain_n;
            stalled   <= stalled_n;
        end
    end

    // Next-state logic. stage_end marks the cycle where a stage's work
    // (beats plus pipeline drain) is complete; the shared block after the
    // case then advances to the next stage or finishes the frame. abort is
    // applied last so it overrides every other transition.
    always_comb begin
        state_n   = state;
        stage_n   = stage_idx;
        beat_n    = beat_idx;
        drain_n   = drain_cnt;
        stalled_n = 1'b0;
        stage_end = 1'b0;

        unique case (state)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_n = LOAD;
                    stage_n = '0;
                    beat_n  = '0;
                end
            end
            LOAD: begin
                state_n = RUN;
                beat_n  = '0;
            end
            RUN: begin
                stalled_n = bus.hold;
                if (!stalled) begin
                    if (beat_idx == LAST_BEAT) begin
                        // Last beat issued: a hold now has nothing to freeze.
                        stalled_n = 1'b0;
                        beat_n    = '0;
                        if (PIPE_LAT == 0) begin
                            stage_end = 1'b1;
                        end else begin
                            state_n = DRAIN;
                            drain_n = DRAIN_LOAD;
                        end
                    end else begin
                        beat_n = beat_idx + 1'b1;
                    end
                end
            end
            DRAIN: begin
                // The counter holds the drain cycles still to spend,
                // including the current one.
                if (drain_cnt <= CW'(1)) begin
                    stage_end = 1'b1;
                    drain_n   = '0;
                end else begin
                    drain_n = drain_cnt - 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (stage_end) begin
            if (stage_idx < LAST_STAGE) begin
                stage_n = stage_idx + 1'b1;
                state_n = LOAD;
            end else begin
                state_n = DONE;
            end
        end

        if (bus.abort && (state != IDLE)) begin
            state_n   = IDLE;
            stage_n   = '0;
            beat_n    = '0;
            drain_n   = '0;
            stalled_n = 1'b0;
        end
    end

    assign bus.busy       = (state != IDLE);
    assign bus.done       = (state == DONE);
    assign bus.stage_idx  = stage_idx;
    assign bus.coeff_sel  = stage_idx;
    assign bus.coeff_load = (state == LOAD);
    assign bus.bf_en      = (state == RUN) && !stalled;
    assign bus.beat_idx   = beat_idx;
    assign bus.rd_bank    = stage_idx[0];

endmodule
